// File: rtl/npu_pkg.sv
// Shared NPU definitions: result-bus geometry, feature-map buffer sizing,
// collector state encoding and the MSB-first channel slice helper used on
// both the producing and collecting side of the result bus.
package npu_pkg;

    localparam int unsigned CH      = 8;              // output channels
    localparam int unsigned DW      = 8;              // bits per pixel
    localparam int unsigned MAX_W   = 128;
    localparam int unsigned MAX_H   = 128;
    localparam int unsigned AW      = 14;             // clog2(MAX_W*MAX_H)
    localparam int unsigned MAX_PIX = MAX_W * MAX_H;
    localparam int unsigned CHW     = $clog2(CH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Channel 0 sits in the most significant byte of the result bus.
    function automatic logic [DW-1:0] ch_slice(input logic [CH*DW-1:0] bus,
                                               input int unsigned      c);
        return bus[(CH-c)*DW-1 -: DW];
    endfunction

endpackage

// File: rtl/npu_out_collector_if.sv
// Result bus (out/out_en) from npu_simple plus the random-access read port
// of the collector.
//   master : producer / reader side (drives out, out_en, rd_en, rd_ch, rd_addr)
//   slave  : collector side (returns rd_data, rd_valid)
interface npu_out_collector_if;
    import npu_pkg::*;

    logic [CH*DW-1:0] out;
    logic [CH-1:0]    out_en;
    logic             rd_en;
    logic [CHW-1:0]   rd_ch;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;

    modport master (
        output out, out_en, rd_en, rd_ch, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  out, out_en, rd_en, rd_ch, rd_addr,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/npu_fmap_bank.sv
// One channel's output feature-map buffer: simple dual-port RAM,
// 2**AW x DW, synchronous write, registered read (1-cycle latency).
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates only when re is high
//   rdata        : read data, old contents on a same-cycle write/read
module npu_fmap_bank
    import npu_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Separate process with NBA: a read hitting the location being
    // written sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/npu_out_collector.sv
// Captures the CH-channel NPU result bus into per-channel feature-map banks
// and exposes them on a 1-cycle-latency read port.
//   clk, reset        : clock, async active-high reset
//   start             : pulse, latches frame_w*frame_h and opens a frame
//   frame_w, frame_h  : map dimensions
//   bus (slave)       : out/out_en result bus and rd_* read port
//   busy              : frame being collected
//   done              : one-cycle pulse when every channel is full
//   overflow          : sticky, unexpected out_en (full channel or not collecting)
//   size_err          : sticky, start with an oversized frame
module npu_out_collector
    import npu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          frame_w,
    input  logic [7:0]          frame_h,
    npu_out_collector_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                size_err
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    state_e               state_q, state_d;
    logic [CH-1:0][AW:0]  ptr_q, ptr_d;
    logic [AW:0]          fs_q, fs_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 serr_q, serr_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [CHW-1:0]       rd_ch_q, rd_ch_d;
    logic                 rd_zero_q, rd_zero_d;
    logic [CH-1:0]        we;
    logic                 all_full;
    logic [15:0]          req_size;
    logic [CH-1:0][DW-1:0] bank_rd;

    // Full-width product so oversized requests (up to 255*255) are caught
    // before truncation to the AW+1-bit frame size.
    assign req_size = 16'(frame_w) * 16'(frame_h);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        fs_d     = fs_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        serr_d   = serr_q;
        we       = '0;
        all_full = 1'b1;
        case (state_q)
            COLLECT: begin
                for (int c = 0; c < CH; c++) begin
                    if (bus.out_en[c]) begin
                        if (ptr_q[c] < fs_q) begin
                            we[c]    = 1'b1;
                            ptr_d[c] = ptr_q[c] + ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    // Compare post-write pointers so done lands right after
                    // the edge that stores the last pixel.
                    if (ptr_d[c] != fs_q) all_full = 1'b0;
                end
                if (all_full) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (|bus.out_en) ovf_d = 1'b1;
                if (start) begin
                    if (req_size > 16'(MAX_PIX)) begin
                        serr_d = 1'b1;
                    end else begin
                        fs_d = req_size[AW:0];
                        if (req_size == 16'd0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            ptr_d   = '0;
                            state_d = COLLECT;
                        end
                    end
                end
            end
        endcase
    end

    // Read side: channel select and out-of-range flag travel with the
    // registered bank data. rd_zero resets high so rd_data reads 0 until
    // the first read completes.
    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_ch_d    = rd_ch_q;
        rd_zero_d  = rd_zero_q;
        if (bus.rd_en) begin
            rd_ch_d   = bus.rd_ch;
            rd_zero_d = ({1'b0, bus.rd_addr} >= (AW+1)'(MAX_PIX));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            fs_q       <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            serr_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_ch_q    <= '0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            fs_q       <= fs_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            serr_q     <= serr_d;
            rd_valid_q <= rd_valid_d;
            rd_ch_q    <= rd_ch_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_bank
        npu_fmap_bank u_bank (
            .clk   (clk),
            .we    (we[c]),
            .waddr (ptr_q[c][AW-1:0]),
            .wdata (ch_slice(bus.out, c)),
            .re    (bus.rd_en),
            .raddr (bus.rd_addr),
            .rdata (bank_rd[c])
        );
    end

    assign bus.rd_data  = rd_zero_q ? '0 : bank_rd[rd_ch_q];
    assign bus.rd_valid = rd_valid_q;
    assign busy         = (state_q == COLLECT);
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign size_err     = serr_q;

endmodule
